fetch_unit: RTL
===============

# fetch_unit

Instruction fetch controller for the core: owns the fetch PC, reads each 44-bit instruction from memory as two 32-bit beats, assembles the instruction and pushes it into the 8-entry `instruction_queue`. It throttles on queue occupancy and, on a branch redirect, discards work in flight and clears the queue. It sits between the memory bus and the queue write port; decode/issue drains the queue independently.

## Interface
- `RESET_PC`, default 0: fetch address after reset; must be 8-byte aligned.
- `ADDR_W`, default 32: address width.
- `IQ_DEPTH`, default 8: queue capacity, compared against `iq_used`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: fetch enable (core running).
- `redirect` in 1: one-cycle branch/jump pulse.
- `redirect_pc` in ADDR_W: new fetch address; bits [2:0] ignored and forced to 0.
- `mem_req` out 1: read request, held high until acknowledged.
- `mem_addr` out ADDR_W: registered read address, stable while `mem_req`=1.
- `mem_ack` in 1: one-cycle pulse; `mem_rdata` valid in the same cycle.
- `mem_rdata` in 32: read data.
- `iq_d` out 44: assembled instruction to the queue.
- `iq_we` out 1: queue write strobe.
- `iq_used` in 8: queue occupancy, 0..IQ_DEPTH.
- `iq_clr` out 1: one-cycle queue clear pulse.
- `fetch_pc` out ADDR_W: address of the instruction currently being fetched.

## Operation
- Instruction at PC: beat HI at PC supplies `iq_d[43:12]` = `mem_rdata[31:0]`. Beat LO at PC+4 supplies `iq_d[11:0]` = `mem_rdata[11:0]`; `mem_rdata[31:12]` is ignored. PC stride is 8, wraps modulo 2^ADDR_W.
- States: IDLE, REQ_HI, REQ_LO, PUSH, DRAIN.
  - IDLE: `mem_req`=0. If `en`=1, go to REQ_HI with `mem_addr`=PC and `mem_req`=1.
  - REQ_HI: on `mem_ack`, capture the high bits, set `mem_addr`=PC+4 and go to REQ_LO. `mem_req` stays 1; back-to-back requests are allowed.
  - REQ_LO: on `mem_ack`, capture the low bits, set `mem_req`=0 and go to PUSH.
  - PUSH: `iq_we` = (`iq_used` < IQ_DEPTH) && !`redirect`, combinational. When written: PC += 8, then go to REQ_HI if `en`=1, else IDLE. If the queue is full, hold in PUSH with `iq_d` stable.
  - DRAIN: keep `mem_req`=1 at the aborted address until `mem_ack`, discard the data, then go to REQ_HI at the new PC if `en`=1, else IDLE.
- Redirect has priority over everything. In any state: PC <= `{redirect_pc[ADDR_W-1:3],3'b0}`, `iq_clr`=1 on the next cycle, and partial assembly is discarded.
  - From REQ_HI/REQ_LO without a same-cycle `mem_ack`: go to DRAIN.
  - With a same-cycle `mem_ack`, or from IDLE/PUSH: go to REQ_HI (if `en`) or IDLE.
  - In DRAIN: PC is updated again and the block stays in DRAIN (or leaves it if `mem_ack` arrives in the same cycle).
- `en` falling mid-instruction: the instruction completes through PUSH, then the block goes to IDLE. `en` never aborts a memory request.
- Concurrent pops by issue are permitted. Only `iq_used` at the PUSH cycle matters; a queue at IQ_DEPTH that pops in that cycle still stalls the push for one cycle, because the queue drops writes when full.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, `mem_req`=0, `mem_addr`=`RESET_PC`, `iq_d`=0, `iq_we`=0, `iq_clr`=0, `fetch_pc`=`RESET_PC`. Reset mid-transaction abandons the request; the memory side is reset by the same `rst`.
- Best case with acks in the cycle after a request: REQ_HI, REQ_LO, PUSH, which gives one instruction per 3 cycles. First `iq_we` arrives 3 cycles after IDLE exits.
- `iq_clr` is registered, asserted exactly one cycle after `redirect`. The next `iq_we` comes at least 2 cycles after `iq_clr`.
- `iq_we` is never high in the same cycle as `redirect` or `iq_clr`.

## Structure
- `core_pkg` holds:
  - `INSTR_W`=44 and `IQ_DEPTH`=8;
  - the fetch state enum `fetch_state_t` (IDLE, REQ_HI, REQ_LO, PUSH, DRAIN);
  - the HI/LO field split constants (43:12, 11:0).
- Single module, no sub-module. The queue gains an `iq_clr` input at integration.

## Test plan
- Reset, `en`=1, memory acks every cycle after request, data HI=0xDEADBEEF, LO=0x00000ABC at PC 0/4 -> `iq_d`=44'hDEADBEEFABC with `iq_we` 3 cycles after IDLE exit; next `mem_addr`=0x8.
- `iq_used`=8 held 5 cycles during PUSH -> `iq_we`=0 and `iq_d` stable; on `iq_used`=7, a single `iq_we` and PC advances by 8.
- `redirect`=1 with `redirect_pc`=0x105 while in REQ_LO with ack delayed 4 cycles -> DRAIN keeps `mem_addr`=0x4 until ack; `iq_clr` pulses once; next request at 0x100; no write of the aborted instruction.
- `redirect` coincident with `mem_ack` in REQ_HI -> no DRAIN; next request is at the redirect target the following cycle.
- `en` dropped in REQ_HI -> instruction completes and is pushed, then IDLE with `mem_req`=0; PC wraps from 0xFFFFFFF8 to 0x0 on the next push.
- `rst` asserted asynchronously mid-REQ_LO -> all outputs return to reset values immediately; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: instruction geometry, queue depth and fetch FSM states.
package core_pkg;

    localparam int unsigned INSTR_W  = 44;
    localparam int unsigned IQ_DEPTH = 8;

    // Field split of one instruction: HI beat -> [43:12], LO beat -> [11:0]
    localparam int unsigned HI_MSB = 43;
    localparam int unsigned HI_LSB = 12;
    localparam int unsigned LO_MSB = 11;
    localparam int unsigned LO_LSB = 0;

    localparam int unsigned FETCH_STRIDE = 8;
    localparam int unsigned BEAT_STRIDE  = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ_HI,
        REQ_LO,
        PUSH,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch controller: reads each 44-bit instruction as two 32-bit beats,
// pushes it into the instruction queue, and handles branch redirects.
module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       IQ_DEPTH = core_pkg::IQ_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [31:0]        mem_rdata,
    output logic [INSTR_W-1:0] iq_d,
    output logic               iq_we,
    input  logic [7:0]         iq_used,
    output logic               iq_clr,
    output logic [ADDR_W-1:0]  fetch_pc
);

    fetch_state_t        r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [INSTR_W-1:0]  r_iq_d;
    logic                r_iq_clr;

    fetch_state_t        w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_cap_hi;
    logic                w_cap_lo;
    logic                w_in_flight;
    logic                w_space;
    logic                w_push;
    logic [ADDR_W-1:0]   w_redir_pc;
    logic [ADDR_W-1:0]   w_pc_plus8;
    logic [2:0]          w_unused_pc_lsb;

    assign w_unused_pc_lsb = redirect_pc[2:0];
    assign w_redir_pc      = {redirect_pc[ADDR_W-1:3], 3'b000};
    assign w_pc_plus8      = r_pc + ADDR_W'(FETCH_STRIDE);
    assign w_in_flight     = (r_state == REQ_HI) || (r_state == REQ_LO) || (r_state == DRAIN);
    assign w_space         = 32'(iq_used) < IQ_DEPTH;
    assign w_push          = (r_state == PUSH) && w_space && !redirect;

    assign mem_req  = w_in_flight;
    assign mem_addr = r_mem_addr;
    assign iq_d     = r_iq_d;
    assign iq_we    = w_push;
    assign iq_clr   = r_iq_clr;
    assign fetch_pc = r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_iq_d     <= '0;
            r_iq_clr   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_mem_addr <= w_addr_nxt;
            r_iq_clr   <= redirect;
            if (w_cap_hi) begin
                r_iq_d[HI_MSB:HI_LSB] <= mem_rdata;
            end
            if (w_cap_lo) begin
                r_iq_d[LO_MSB:LO_LSB] <= mem_rdata[LO_MSB-LO_LSB:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_mem_addr;
        w_cap_hi    = 1'b0;
        w_cap_lo    = 1'b0;

        if (redirect) begin
            w_pc_nxt = w_redir_pc;
            // An unacknowledged bus request cannot be withdrawn, so it is drained at its old address
            if (w_in_flight && !mem_ack) begin
                w_state_nxt = DRAIN;
            end else if (en) begin
                w_state_nxt = REQ_HI;
                w_addr_nxt  = w_redir_pc;
            end else begin
                w_state_nxt = IDLE;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (en) begin
                        w_state_nxt = REQ_HI;
                        w_addr_nxt  = r_pc;
                    end
                end
                REQ_HI: begin
                    if (mem_ack) begin
                        w_cap_hi    = 1'b1;
                        w_addr_nxt  = r_pc + ADDR_W'(BEAT_STRIDE);
                        w_state_nxt = REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (mem_ack) begin
                        w_cap_lo    = 1'b1;
                        w_state_nxt = PUSH;
                    end
                end
                PUSH: begin
                    if (w_push) begin
                        w_pc_nxt = w_pc_plus8;
                        if (en) begin
                            w_state_nxt = REQ_HI;
                            w_addr_nxt  = w_pc_plus8;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        if (en) begin
                            w_state_nxt = REQ_HI;
                            w_addr_nxt  = r_pc;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
